traveler_cmd_dispatcher: RTL and testbench

Arbitrates traveler operation commands from two sources and sequences them onto a single byte-wide transmit link to the game host. Sources are the manual button encoder's toggle-marked 9-bit bus and an automatic/scripted command source with valid/ready. The dispatcher validates and queues commands in a small FIFO, then emits them one at a time with a valid/ready handshake. A configurable quiet gap between transmitted commands keeps the host from being flooded.

---
 rtl/traveler_cmd_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/traveler_cmd_dispatcher.sv | 153 +++++++++++++++
 tb/tb_traveler_cmd_dispatcher.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traveler_cmd_pkg.sv
// Shared opcodes, command tag, dispatcher states and the command validity rule
// for the traveler command dispatcher.
package traveler_cmd_pkg;

  localparam logic [7:0] OP_MOVE     = 8'h22;
  localparam logic [7:0] OP_THROW    = 8'h42;
  localparam logic [7:0] OP_INTERACT = 8'h12;
  localparam logic [7:0] OP_GET      = 8'h06;
  localparam logic [7:0] OP_PUT      = 8'h0A;

  localparam logic [1:0] CMD_TAG = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } disp_state_e;

  // Tag must match and the operation field must be exactly one-hot; bit 7 is don't-care.
  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    logic [7:0] c;
    logic [4:0] sel;
    c   = cmd & 8'h7F;
    sel = c[6:2];
    return (c[1:0] == CMD_TAG) && (sel != 5'd0) && ((sel & (sel - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command queue; full/empty come from the registered count,
// so a push into a full queue is refused even when a pop happens that cycle.
module cmd_fifo
  import traveler_cmd_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/traveler_cmd_dispatcher.sv
// Arbitrates manual (toggle-marked) and automatic traveler commands into a queue
// and paces them onto the host link with a quiet gap after every accepted byte.
module traveler_cmd_dispatcher
  import traveler_cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 5_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] man_data,
  input  logic       auto_enable,
  input  logic       auto_valid,
  input  logic [7:0] auto_cmd,
  output logic       auto_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             primed_r;
  logic             prev_mark_r;
  logic             man_event_s;
  logic             auto_ready_s;
  logic             auto_fire_s;
  logic             push_s;
  logic [7:0]       push_data_s;
  logic             drop_s;
  logic             pop_s;
  logic [7:0]       fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  disp_state_e      state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;
  logic [7:0]       drop_cnt_r;

  // First cycle out of reset only captures the mark, so a high mark is not an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_r    <= 1'b0;
      prev_mark_r <= 1'b0;
    end else begin
      primed_r    <= 1'b1;
      prev_mark_r <= man_data[8];
    end
  end

  // Source arbitration: a manual event always wins and blocks the automatic source
  always_comb begin
    man_event_s  = primed_r & (man_data[8] ^ prev_mark_r);
    auto_ready_s = primed_r & auto_enable & ~fifo_full_s & ~man_event_s;
    auto_fire_s  = auto_valid & auto_ready_s;
    push_s       = 1'b0;
    push_data_s  = 8'h00;
    drop_s       = 1'b0;
    if (man_event_s) begin
      if (cmd_is_valid(man_data[7:0]) && !fifo_full_s) begin
        push_s      = 1'b1;
        push_data_s = man_data[7:0] & 8'h7F;
      end else begin
        drop_s = 1'b1;
      end
    end else if (auto_fire_s) begin
      if (cmd_is_valid(auto_cmd)) begin
        push_s      = 1'b1;
        push_data_s = auto_cmd & 8'h7F;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s = (state_r == IDLE) & ~fifo_empty_s;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Transmit sequencer: present one byte, wait for handshake, then hold off the link
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gap_cnt_r  <= GAP_W'(0);
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            tx_data_r  <= fifo_head_s;
            tx_valid_r <= 1'b1;
            state_r    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_r <= 1'b0;
            gap_cnt_r  <= GAP_W'(GAP_CYCLES - 1);
            state_r    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_W'(0)) begin
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'h00;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign auto_ready = auto_ready_s;
  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;
  assign drop_cnt   = drop_cnt_r;
  assign busy       = (state_r != IDLE) | (fifo_count_s != CNT_W'(0));

endmodule

// File: tb/tb_traveler_cmd_dispatcher.sv
// Directed and randomized bench for traveler_cmd_dispatcher; a queue of expected
// transmit bytes and an expected drop count serve as the reference model.
module tb_traveler_cmd_dispatcher;

  localparam int GAP_CYCLES = 4;
  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [8:0] man_data;
  logic       auto_enable;
  logic       auto_valid;
  logic [7:0] auto_cmd;
  logic       auto_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic [7:0] drop_cnt;

  traveler_cmd_dispatcher #(
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .man_data    (man_data),
    .auto_enable (auto_enable),
    .auto_valid  (auto_valid),
    .auto_cmd    (auto_cmd),
    .auto_ready  (auto_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         exp_drop = 0;
  bit         man_model = 1'b1;
  bit         m_primed  = 1'b0;
  logic       m_mark    = 1'b0;
  logic       v_prev    = 1'b0;
  logic       hs_prev   = 1'b0;
  logic [7:0] d_prev    = 8'h00;
  bit         seen_hs   = 1'b0;
  int         idx       = 0;
  int         hs_idx    = 0;
  int         last_gap  = 0;
  logic [7:0] fill_cmds [6] = '{8'h22, 8'h42, 8'h12, 8'h06, 8'h0A, 8'h22};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cmd_ok(input logic [7:0] c);
    logic [7:0] m;
    m = c & 8'h7F;
    return (m == 8'h22) || (m == 8'h42) || (m == 8'h12) || (m == 8'h06) || (m == 8'h0A);
  endfunction

  function automatic logic [7:0] rand_cmd();
    logic [7:0] ops [5];
    ops = '{8'h22, 8'h42, 8'h12, 8'h06, 8'h0A};
    if ($urandom_range(0, 2) == 0) return 8'($urandom);
    return ops[$urandom_range(0, 4)] | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00);
  endfunction

  task automatic model_cmd(input logic [7:0] c);
    if (cmd_ok(c)) exp_q.push_back(c & 8'h7F);
    else if (exp_drop < 255) exp_drop++;
  endtask

  // One clock: observe pre-edge, update the model, then sample post-edge state
  task automatic step();
    logic       hs, v, ev, acc;
    logic [7:0] d, mc, ac;
    @(negedge clk);
    v   = tx_valid;
    d   = tx_data;
    hs  = tx_valid & tx_ready;
    acc = auto_valid & auto_ready;
    ev  = m_primed && (man_data[8] != m_mark);
    mc  = man_data[7:0];
    ac  = auto_cmd;
    if (rst_n) begin
      if (!m_primed) chk("auto_ready_priming", auto_ready, 1'b0);
      else if (ev) chk("auto_ready_man_prio", auto_ready, 1'b0);
      else if (auto_enable && exp_q.size() < FIFO_DEPTH) chk("auto_ready_room", auto_ready, 1'b1);
      if (v_prev && !hs_prev) begin
        chk("tx_valid_held", v, 1'b1);
        chk("tx_data_held", d, d_prev);
      end
      if (v && !v_prev && seen_hs) begin
        last_gap = idx - hs_idx - 1;
        chk("gap_min", (last_gap >= GAP_CYCLES + 1), 1'b1);
      end
      if (hs) begin
        chk("tx_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) chk("tx_data", d, exp_q.pop_front());
        seen_hs = 1'b1;
        hs_idx  = idx;
      end
      if (man_model && ev) model_cmd(mc);
      if (acc) model_cmd(ac);
      m_mark   = man_data[8];
      m_primed = 1'b1;
    end
    v_prev  = v;
    hs_prev = hs;
    d_prev  = d;
    @(posedge clk);
    #1;
    idx++;
    if (rst_n) chk("drop_cnt", drop_cnt, exp_drop[7:0]);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk("idle_reached", (busy == 1'b0 && exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n       = 1'b0;
    man_data    = 9'h022;
    auto_enable = 1'b0;
    auto_valid  = 1'b0;
    auto_cmd    = 8'h00;
    tx_ready    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_auto_ready", auto_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Single manual move with the link always ready
    man_data = 9'h122;
    step();
    chk("t1_not_yet_valid", tx_valid, 1'b0);
    chk("t1_busy_queued", busy, 1'b1);
    step();
    chk("t1_valid", tx_valid, 1'b1);
    chk("t1_data", tx_data, 8'h22);
    step();
    chk("t1_valid_one_cycle", tx_valid, 1'b0);
    repeat (3) step();
    chk("t1_busy_in_gap", busy, 1'b1);
    step();
    chk("t1_busy_falls", busy, 1'b0);

    // Manual and automatic offered together: manual first, auto next cycle
    man_data    = {~man_data[8], 8'h42};
    auto_enable = 1'b1;
    auto_valid  = 1'b1;
    auto_cmd    = 8'h0A;
    #1;
    chk("t2_auto_blocked", auto_ready, 1'b0);
    step();
    chk("t2_auto_ready_next", auto_ready, 1'b1);
    step();
    auto_valid  = 1'b0;
    auto_enable = 1'b0;
    wait_idle(100);
    chk("t2_gap_exact", last_gap, GAP_CYCLES + 1);

    // Transmitter stall for 20 cycles
    tx_ready = 1'b0;
    man_data = {~man_data[8], 8'h12};
    step();
    step();
    chk("t3_valid", tx_valid, 1'b1);
    repeat (20) step();
    chk("t3_still_valid", tx_valid, 1'b1);
    chk("t3_data_stable", tx_data, 8'h12);
    tx_ready = 1'b1;
    step();
    chk("t3_released", tx_valid, 1'b0);
    wait_idle(100);

    // Six toggles while stalled: one in flight, four queued, one dropped
    tx_ready  = 1'b0;
    man_model = 1'b0;
    for (int i = 0; i < 6; i++) begin
      man_data = {~man_data[8], fill_cmds[i]};
      if (i < 5) exp_q.push_back(fill_cmds[i]);
      else exp_drop++;
      step();
    end
    chk("t4_head_in_send", tx_data, 8'h22);
    chk("t4_busy", busy, 1'b1);
    auto_enable = 1'b1;
    #1;
    chk("t4_full_blocks_auto", auto_ready, 1'b0);
    auto_enable = 1'b0;
    man_model   = 1'b1;
    tx_ready    = 1'b1;
    wait_idle(200);
    chk("t4_gap_exact", last_gap, GAP_CYCLES + 1);

    // Invalid commands from both sources are dropped, nothing transmitted
    d0       = exp_drop;
    man_data = {~man_data[8], 8'h26};
    step();
    man_data = {~man_data[8], 8'h21};
    step();
    repeat (10) step();
    chk("t5_drop_two", drop_cnt, d0 + 2);
    chk("t5_nothing_sent", busy, 1'b0);
    auto_enable = 1'b1;
    auto_valid  = 1'b1;
    auto_cmd    = 8'h0B;
    step();
    auto_valid = 1'b0;
    step();
    chk("t5_auto_drop", drop_cnt, d0 + 3);

    // Randomized traffic, kept below the queue depth so no overflow occurs
    for (int i = 0; i < 400; i++) begin
      tx_ready    = ($urandom_range(0, 3) != 0);
      auto_enable = $urandom_range(0, 1) == 1;
      auto_valid  = (exp_q.size() < FIFO_DEPTH) && ($urandom_range(0, 2) == 0);
      auto_cmd    = rand_cmd();
      if ((exp_q.size() < FIFO_DEPTH) && ($urandom_range(0, 3) == 0))
        man_data = {~man_data[8], rand_cmd()};
      step();
    end
    tx_ready    = 1'b1;
    auto_valid  = 1'b0;
    auto_enable = 1'b0;
    wait_idle(200);

    // Reset during the gap with a queued command and the mark high at release
    man_data = {~man_data[8], 8'h22};
    step();
    man_data = {~man_data[8], 8'h06};
    step();
    step();
    step();
    chk("t6_in_gap", tx_valid, 1'b0);
    rst_n    = 1'b0;
    man_data = {1'b1, 8'h42};
    #1;
    chk("t6_rst_tx_valid", tx_valid, 1'b0);
    chk("t6_rst_tx_data", tx_data, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_drop", drop_cnt, 8'h00);
    chk("t6_rst_auto_ready", auto_ready, 1'b0);
    exp_q.delete();
    exp_drop = 0;
    m_primed = 1'b0;
    v_prev   = 1'b0;
    hs_prev  = 1'b0;
    seen_hs  = 1'b0;
    repeat (3) step();
    rst_n       = 1'b1;
    auto_enable = 1'b1;
    repeat (20) step();
    chk("t6_no_spurious_tx", tx_valid, 1'b0);
    chk("t6_idle_after", busy, 1'b0);
    auto_enable = 1'b0;

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      man_data = {~man_data[8], 8'h26};
      step();
    end
    chk("t7_drop_saturated", drop_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
